// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory initiator: write-strobe encodings, FSM state type
// and the request legality rule.
package mem_bus_pkg;

  localparam logic [3:0] WSTRB_READ = 4'b0000;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUS_WAIT = 2'd1,
    ST_RESPOND  = 2'd2
  } init_state_e;

  // Only word-aligned reads and full-word writes are issued on the bus.
  function automatic logic req_is_legal(input logic [1:0] addr_lo, input logic [3:0] wstrb);
    return (addr_lo == 2'b00) && ((wstrb == WSTRB_READ) || (wstrb == WSTRB_WORD));
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Core-request, response and responder-bus signals of the memory initiator.
// master = the initiator's view, slave = the core/responder environment's view.
interface mem_initiator_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/mem_initiator.sv
// Single-outstanding memory initiator: accepts one core request, runs one bus cycle
// with a wait-state timeout and returns a one-cycle response pulse.
//
//   state       | meaning
//   ST_IDLE     | ready for a request, bus idle
//   ST_BUS_WAIT | mem_valid held, waiting for mem_ready or timeout
//   ST_RESPOND  | resp_valid pulse, bus idle for one cycle
module mem_initiator
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  mem_initiator_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  init_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          cnt_d   = '0;
          if (req_is_legal(bus.req_addr[1:0], bus.req_wstrb)) begin
            state_d = ST_BUS_WAIT;
          end else begin
            state_d = ST_RESPOND;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end

      ST_BUS_WAIT: begin
        // A completion in the last allowed cycle beats the timeout.
        if (bus.mem_ready) begin
          state_d = ST_RESPOND;
          err_d   = 1'b0;
          rdata_d = (wstrb_q == WSTRB_READ) ? bus.mem_rdata : '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESPOND;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESPOND: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Gated by reset so an aborted transaction never shows a pulse or an accept.
  assign bus.req_ready  = (state_q == ST_IDLE) && !reset;
  assign bus.resp_valid = (state_q == ST_RESPOND) && !reset;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_valid  = (state_q == ST_BUS_WAIT);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wstrb  = wstrb_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized bench for mem_initiator: a wait-state responder, a transaction-level
// reference model and a cycle monitor for pulse width, bus gaps and response hold.
module tb_mem_initiator;
  import mem_bus_pkg::*;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;

  mem_initiator_if bus();

  mem_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  logic [31:0] resp_mem  [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  int rsp_wait   = 0;
  bit late_ready = 1'b0;

  // Responder: ready pulse rsp_wait cycles after first seeing mem_valid (-1 = never).
  initial begin
    int seen;
    seen = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_valid === 1'b1) begin
        if (rsp_wait >= 0 && seen == rsp_wait) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_wstrb == WSTRB_WORD)
            resp_mem[bus.mem_addr] = bus.mem_wdata;
          else
            bus.mem_rdata = resp_mem.exists(bus.mem_addr) ? resp_mem[bus.mem_addr] : dflt(bus.mem_addr);
        end
        seen++;
      end else begin
        seen = 0;
        if (late_ready) begin
          bus.mem_ready = 1'b1;
          late_ready    = 1'b0;
        end
      end
    end
  end

  // Cycle monitor.
  initial begin
    bit pv, pmv, pmr, prst;
    logic [32:0] last_resp;
    pv = 0; pmv = 0; pmr = 0; prst = 1; last_resp = '0;
    forever begin
      @(negedge clk);
      #1;
      if (pv) chk("resp_one_cycle", 64'(bus.resp_valid), 64'(1'b0));
      if (pv && !prst) chk("resp_hold", 64'({bus.resp_rdata, bus.resp_err}), 64'(last_resp));
      if (pmv && pmr) chk("mem_valid_gap", 64'(bus.mem_valid), 64'(1'b0));
      if (bus.resp_valid === 1'b1) last_resp = {bus.resp_rdata, bus.resp_err};
      pv   = (bus.resp_valid === 1'b1);
      pmv  = (bus.mem_valid === 1'b1);
      pmr  = (bus.mem_ready === 1'b1);
      prst = (reset === 1'b1);
    end
  end

  // One transaction, started and finished on a falling edge; finishes in the
  // response cycle with req_valid low so the next call may chain directly.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int wait_n, input bit chained);
    bit legal, tmo, got;
    int exp_lat, exp_mv, waited, k, mv_cnt, unstable;
    logic exp_err;
    logic [31:0] exp_rd;

    legal = (addr % 4 == 0) && (wstrb == 4'h0 || wstrb == 4'hF);
    tmo   = legal && (wait_n < 0 || wait_n >= TMO);
    if (!legal) begin
      exp_lat = 1; exp_mv = 0; exp_err = 1'b1; exp_rd = '0;
    end else if (tmo) begin
      exp_lat = TMO + 1; exp_mv = TMO; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_lat = wait_n + 2; exp_mv = wait_n + 1; exp_err = 1'b0;
      if (wstrb == 4'hF) begin
        model_mem[addr] = wdata;
        exp_rd = '0;
      end else begin
        exp_rd = model_mem.exists(addr) ? model_mem[addr] : dflt(addr);
      end
    end

    rsp_wait      = wait_n;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_wait", 64'(waited), chained ? 64'd1 : 64'd0);
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      return;
    end

    @(posedge clk);
    k = 0; mv_cnt = 0; unstable = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      bus.req_valid = 1'b0;
      if (bus.mem_valid === 1'b1) begin
        mv_cnt++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {addr, wdata, wstrb}) unstable++;
      end
      if (bus.resp_valid === 1'b1) got = 1;
    end
    chk("resp_latency", 64'(k), 64'(exp_lat));
    chk("mem_valid_cycles", 64'(mv_cnt), 64'(exp_mv));
    chk("mem_stable", 64'(unstable), 64'd0);
    chk("resp_err", 64'(bus.resp_err), 64'(exp_err));
    chk("resp_rdata", 64'(bus.resp_rdata), 64'(exp_rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_rv, bad_idle;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    resp_mem[32'h10]  = 32'hDEAD_BEEF;
    model_mem[32'h10] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_valids", 64'({bus.mem_valid, bus.resp_valid, bus.resp_err}), 64'd0);
    chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("rst_mem_regs", 64'({bus.mem_addr, bus.mem_wdata}), 64'd0);
    chk("rst_mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

    // Three-wait-state read, then write/read-back of 0x20.
    run_txn(32'h10, 32'h0, 4'h0, 3, 0);
    @(negedge clk);
    run_txn(32'h20, 32'h1234_5678, 4'hF, 2, 0);
    repeat (2) @(negedge clk);
    run_txn(32'h20, 32'h0, 4'h0, 1, 0);

    // Illegal requests never reach the bus.
    @(negedge clk);
    run_txn(32'h22, 32'h0, 4'h0, 0, 0);
    @(negedge clk);
    run_txn(32'h20, 32'hFFFF_FFFF, 4'b0011, 0, 0);

    // Timeout, then a late ready pulse that must be ignored.
    @(negedge clk);
    run_txn(32'h30, 32'h0, 4'h0, -1, 0);
    repeat (3) @(negedge clk);
    late_ready = 1'b1;
    cnt_rv = 0; bad_idle = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) cnt_rv++;
      if (bus.req_ready !== 1'b1 || bus.resp_err !== 1'b1 || bus.mem_valid !== 1'b0) bad_idle++;
    end
    chk("late_ready_resp", 64'(cnt_rv), 64'd0);
    chk("late_ready_idle", 64'(bad_idle), 64'd0);

    // Ready on the last allowed cycle wins; one cycle later is a timeout.
    run_txn(32'h20, 32'h0, 4'h0, TMO - 1, 0);
    @(negedge clk);
    run_txn(32'h24, 32'hCAFE_F00D, 4'hF, TMO, 0);

    // Reset in the middle of a bus wait.
    @(negedge clk);
    rsp_wait      = -1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wstrb = 4'h0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("busy_mem_valid", 64'(bus.mem_valid), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("abort_resp", 64'({bus.resp_valid, bus.resp_err, bus.resp_rdata}), 64'd0);
    chk("abort_mem_addr", 64'(bus.mem_addr), 64'd0);
    reset  = 1'b0;
    cnt_rv = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1 || bus.mem_valid === 1'b1) cnt_rv++;
    end
    chk("abort_quiet", 64'(cnt_rv), 64'd0);
    run_txn(32'h10, 32'h0, 4'h0, 2, 0);

    // Back-to-back reads with req_valid kept high.
    @(negedge clk);
    run_txn(32'h10, 32'h0, 4'h0, 1, 0);
    run_txn(32'h20, 32'h0, 4'h0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [3:0]  s;
      int w, r;
      bit ch;
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      s = (r < 4) ? 4'h0 : (r < 8) ? 4'hF : 4'($urandom_range(1, 14));
      w = $urandom_range(0, 10);
      if (w == 10) w = -1;
      ch = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (!ch) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_txn(a, $urandom, s, w, ch);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
